// File: rtl/coin_detect.sv
// coin_detect: synchronises and debounces two coin sensors, then serialises coin
// events into single-cycle codes on coin_out with a guaranteed idle gap.
//   state | meaning
//   IDLE  | waiting for a pending coin (1-yuan first)
//   PULSE | code on coin_out for exactly one cycle; tally it
//   GAP   | hold coin_out at 0 for GAP_CYC cycles
module coin_detect #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int GAP_CYC      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    output logic [1:0] coin_out,
    output logic       coin_err,
    output logic [7:0] total_yuan
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t            state_q;
    logic [1:0]        s1_q, s2_q;
    logic [1:0]        db_q, db_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        rise, clr;
    logic              lost;
    logic              err_q;
    logic [1:0]        out_q;
    logic [7:0]        tot_q;
    logic [GW-1:0]     gcnt_q;
    logic [8:0]        sum;

    // bit 0 carries the 1-yuan channel, bit 1 the 2-yuan channel
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise   = db_d & ~db_q;
    assign clr[0] = (state_q == IDLE) && pend_q[0];
    assign clr[1] = (state_q == IDLE) && !pend_q[0] && pend_q[1];
    // a new event on the clearing edge re-arms the slot instead of being lost
    assign pend_d = rise | (pend_q & ~clr);
    assign lost   = |(rise & pend_q & ~clr);
    assign sum    = {1'b0, tot_q} + {7'b0, out_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            s1_q   <= {coin2_raw, coin1_raw};
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            if (lost) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 2'b00;
            tot_q   <= 8'd0;
            gcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q[0]) begin
                        out_q   <= 2'b01;
                        state_q <= PULSE;
                    end else if (pend_q[1]) begin
                        out_q   <= 2'b10;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    out_q   <= 2'b00;
                    tot_q   <= sum[8] ? 8'hFF : sum[7:0];
                    gcnt_q  <= '0;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gcnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_out   = out_q;
    assign coin_err   = err_q;
    assign total_yuan = tot_q;
endmodule

// File: doc/coin_detect.md
Name: coin_detect

Overview:
Input conditioner placed directly upstream of the vending state machine. It takes two raw, asynchronous, bouncy coin-sensor lines (1-yuan and 2-yuan) and delivers clean single-cycle coin codes on the 2-bit `in` bus that the vending FSM consumes.
- Every coin code is followed by at least GAP_CYC idle cycles.
- Simultaneous coins are serialised.
- Coins that cannot be buffered are flagged, and accepted value is tallied.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable cycles required before a synchronised level change is accepted (>=2)
GAP_CYC, 1, minimum coin_out==0 cycles after each pulse (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
coin1_raw  input  1  1-yuan sensor, asynchronous, active-high, may bounce
coin2_raw  input  1  2-yuan sensor, asynchronous, active-high, may bounce
coin_out  output  2  coin code to vending FSM: 2'b00 none, 2'b01 one yuan, 2'b10 two yuan; never 2'b11
coin_err  output  1  sticky: a coin was lost because its pending slot was already full
total_yuan  output  8  saturating count of yuan emitted on coin_out

Behaviour:
Interface and reset:
- One clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n=0: coin_out=2'b00, coin_err=0, total_yuan=0; synchronisers, debounced levels, counters and pending flags cleared; FSM in IDLE.

Synchroniser:
- Each raw line passes through a 2-flop synchroniser: s1 <= raw; s2 <= s1.

Debounce (per channel):
- State is a debounced level db and a counter cnt of width clog2(DEBOUNCE_CYC).
- If s2==db: cnt <= 0.
- Else if cnt==DEBOUNCE_CYC-1: db <= s2, cnt <= 0.
- Else: cnt <= cnt+1.
- Any s2 disagreement shorter than DEBOUNCE_CYC cycles is ignored.
- A db 0->1 transition is a coin event for that channel. Falling transitions produce nothing.

Pending flags (pend1, pend2, one slot each):
- A coin event sets its flag on the same edge db rises.
- If an event occurs while its flag is already set and the flag is not being cleared that edge: coin_err <= 1 (sticky until reset), and the event is dropped.
- If the FSM clears a flag on the same edge a new event of that channel arrives, set wins: the flag stays 1 and there is no error.

Emit FSM, states IDLE, PULSE, GAP:
- IDLE:
  - if pend1: coin_out <= 2'b01, clear pend1, go to PULSE;
  - else if pend2: coin_out <= 2'b10, clear pend2, go to PULSE;
  - else stay (1-yuan has priority).
- PULSE (exactly 1 cycle): coin_out <= 2'b00; total_yuan <= min(255, total_yuan + code); gap counter <= 0; go to GAP.
- GAP: coin_out stays 0. After GAP_CYC cycles with coin_out==0, go to IDLE.
- Back-to-back coins therefore appear no closer than every GAP_CYC+2 cycles.

Latency:
- Raw level first sampled high at edge 0, FSM idle, no pending: db rises at edge DEBOUNCE_CYC+1; coin_out is driven 1 on edge DEBOUNCE_CYC+2. With defaults, coin_out is high from edge 6 to edge 7.

Arithmetic:
- total_yuan holds at 255 once reached. It never wraps.

Reset mid-operation:
- Asserting rst_n discards any pulse in progress, pending coins and partial debounce counts. coin_out drops to 0 immediately (asynchronously).
- A raw line still high after release is treated as a new rising level and is reported after full debounce.

Test Plan:
- Clean 1-yuan: coin1_raw high for 10 cycles, defaults -> coin_out=2'b01 for exactly 1 cycle, 6 edges after raw first sampled high; then 0; total_yuan=1; coin_err=0.
- Glitch rejection: coin2_raw pulses high for 3 cycles, then bounces 1/0 every cycle for 6 cycles, then low -> coin_out stays 0; total_yuan unchanged.
- Bounce then stable: coin2_raw bounces 5 cycles, then holds high 10 cycles -> exactly one 2'b10 pulse; total_yuan += 2.
- Simultaneous coins: both raw lines rise on the same cycle and hold 10 cycles -> 2'b01 pulse, at least one 0 cycle (GAP_CYC=1), then 2'b10 pulse; total_yuan += 3; no 2'b11 ever.
- Overflow: with GAP_CYC=20, three debounced coin1 events within 20 cycles -> one pulse emitted, one held pending, third dropped; coin_err=1 and it stays 1 until reset. Also: 86 two-yuan coins (172 yuan) followed by 42 more two-yuan coins (256 yuan cumulative) -> total_yuan saturates at 255.
- Reset mid-pulse: assert rst_n=0 while coin_out=2'b01 -> coin_out=0, total_yuan=0, coin_err=0 immediately. Release with coin1_raw held high -> one 2'b01 pulse 6 edges after release.
